// File: rtl/zeroriscy_sram_arb.sv
// Two-requester round-robin arbiter in front of a single-ported SRAM.
// Out-of-window accesses are granted locally and answered with an error response.
module zeroriscy_sram_arb #(
   parameter logic [31:0] WIN_MASK = 32'hFFF0_0000,
   parameter logic [31:0] WIN_BASE = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [3:0]  m0_be,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   output logic        m0_err,
   output logic [31:0] m0_rdata,

   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [3:0]  m1_be,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   output logic        m1_err,
   output logic [31:0] m1_rdata,

   output logic        s_req,
   output logic        s_we,
   output logic [3:0]  s_be,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   input  logic        s_gnt,
   input  logic        s_rvalid,
   input  logic [31:0] s_rdata
);

   typedef enum logic [2:0] {
      OWN_NONE,
      OWN_M0,
      OWN_M1,
      OWN_ERR0,
      OWN_ERR1
   } owner_t;

   owner_t owner;
   logic   last_m1;

   logic m0_in_win;
   logic m1_in_win;
   logic sel_m0;
   logic sel_m1;

   assign m0_in_win = (m0_addr & WIN_MASK) == WIN_BASE;
   assign m1_in_win = (m1_addr & WIN_MASK) == WIN_BASE;

   // On a conflict the requester that did not win most recently goes first.
   assign sel_m0 = m0_req && (!m1_req || last_m1);
   assign sel_m1 = m1_req && !sel_m0;

   // Request path: in-window winners wait on s_gnt; out-of-window winners are
   // granted locally and never reach the SRAM.
   always_comb begin
      s_req   = 1'b0;
      s_we    = 1'b0;
      s_be    = 4'b0000;
      s_addr  = 32'h0;
      s_wdata = 32'h0;
      m0_gnt  = 1'b0;
      m1_gnt  = 1'b0;
      if (!rst) begin
         if (sel_m0) begin
            if (m0_in_win) begin
               s_req   = 1'b1;
               s_we    = m0_we;
               s_be    = m0_be;
               s_addr  = m0_addr;
               s_wdata = m0_wdata;
               m0_gnt  = s_gnt;
            end else begin
               m0_gnt  = 1'b1;
            end
         end else if (sel_m1) begin
            if (m1_in_win) begin
               s_req   = 1'b1;
               s_we    = m1_we;
               s_be    = m1_be;
               s_addr  = m1_addr;
               s_wdata = m1_wdata;
               m1_gnt  = s_gnt;
            end else begin
               m1_gnt  = 1'b1;
            end
         end
      end
   end

   // Response path is steered by the owner captured at the previous grant;
   // reset squashes anything arriving while it is asserted.
   always_comb begin
      m0_rvalid = 1'b0;
      m0_err    = 1'b0;
      m0_rdata  = 32'h0;
      m1_rvalid = 1'b0;
      m1_err    = 1'b0;
      m1_rdata  = 32'h0;
      if (!rst) begin
         case (owner)
            OWN_M0: begin
               m0_rvalid = s_rvalid;
               m0_rdata  = s_rdata;
            end
            OWN_M1: begin
               m1_rvalid = s_rvalid;
               m1_rdata  = s_rdata;
            end
            OWN_ERR0: begin
               m0_rvalid = 1'b1;
               m0_err    = 1'b1;
            end
            OWN_ERR1: begin
               m1_rvalid = 1'b1;
               m1_err    = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Pointer moves only on a real grant; owner is reloaded every cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner   <= OWN_NONE;
         last_m1 <= 1'b1;
      end else if (m0_gnt) begin
         last_m1 <= 1'b0;
         owner   <= m0_in_win ? OWN_M0 : OWN_ERR0;
      end else if (m1_gnt) begin
         last_m1 <= 1'b1;
         owner   <= m1_in_win ? OWN_M1 : OWN_ERR1;
      end else begin
         owner   <= OWN_NONE;
      end
   end

endmodule

// File: tb/tb_zeroriscy_sram_arb.sv
// Directed bench for zeroriscy_sram_arb: arbitration order, windowing,
// stalls, writes and reset behaviour, with hand-computed expectations.
module tb_zeroriscy_sram_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req, m0_we;
   logic [3:0]  m0_be;
   logic [31:0] m0_addr, m0_wdata;
   logic        m0_gnt, m0_rvalid, m0_err;
   logic [31:0] m0_rdata;
   logic        m1_req, m1_we;
   logic [3:0]  m1_be;
   logic [31:0] m1_addr, m1_wdata;
   logic        m1_gnt, m1_rvalid, m1_err;
   logic [31:0] m1_rdata;
   logic        s_req, s_we;
   logic [3:0]  s_be;
   logic [31:0] s_addr, s_wdata;
   logic        s_gnt, s_rvalid;
   logic [31:0] s_rdata;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   zeroriscy_sram_arb dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_err(m0_err), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_err(m1_err), .m1_rdata(m1_rdata),
      .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata)
   );

   // Inputs change 1ns after the rising edge; outputs are sampled 2ns later.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic idle_inputs();
      m0_req = 0; m0_we = 0; m0_be = 4'hF; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_we = 0; m1_be = 4'hF; m1_addr = 0; m1_wdata = 0;
      s_gnt = 0; s_rvalid = 0; s_rdata = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      next_cycle();
      next_cycle();
      rst = 0;
      s_rvalid = 1; s_rdata = 32'h1111_1111;
      settle();
      checks++;
      if ({m0_rvalid, m0_err, m1_rvalid, m1_err} !== 4'b0000 || m0_rdata !== 0 || m1_rdata !== 0) begin
         failures++;
         $display("[TB] FAIL reset_resp: got rv0=%b er0=%b rd0=%h rv1=%b er1=%b rd1=%h, expected all 0",
                  m0_rvalid, m0_err, m0_rdata, m1_rvalid, m1_err, m1_rdata);
      end
      checks++;
      if ({s_req, m0_gnt, m1_gnt} !== 3'b000) begin
         failures++;
         $display("[TB] FAIL reset_idle: got s_req=%b gnt0=%b gnt1=%b, expected 0 0 0", s_req, m0_gnt, m1_gnt);
      end
      s_rvalid = 0;
      next_cycle();
   endtask

   // Both requesting every cycle: m0, m1, m0, m1, each answered one cycle later.
   task automatic test_round_robin();
      logic [1:0] exp_gnt [4];
      exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b10;
      m0_req = 1; m0_addr = 32'h0000_0010;
      m1_req = 1; m1_addr = 32'h0000_0020;
      s_gnt = 1;
      for (int k = 0; k <= 4; k++) begin
         if (k == 4) begin
            m0_req = 0; m1_req = 0;
         end
         s_rvalid = (k > 0);
         s_rdata  = 32'hA000_0000 + k;
         settle();
         if (k < 4) begin
            checks++;
            if ({m1_gnt, m0_gnt} !== exp_gnt[k]) begin
               failures++;
               $display("[TB] FAIL rr_gnt[%0d]: got {gnt1,gnt0}=%b, expected %b", k, {m1_gnt, m0_gnt}, exp_gnt[k]);
            end
            checks++;
            if (s_addr !== (exp_gnt[k][0] ? 32'h10 : 32'h20)) begin
               failures++;
               $display("[TB] FAIL rr_addr[%0d]: got %h, expected %h", k, s_addr, exp_gnt[k][0] ? 32'h10 : 32'h20);
            end
         end
         if (k > 0) begin
            checks++;
            if ({m1_rvalid, m0_rvalid} !== exp_gnt[k-1]) begin
               failures++;
               $display("[TB] FAIL rr_rvalid[%0d]: got {rv1,rv0}=%b, expected %b", k, {m1_rvalid, m0_rvalid}, exp_gnt[k-1]);
            end
            checks++;
            if ((exp_gnt[k-1][0] ? m0_rdata : m1_rdata) !== 32'hA000_0000 + k) begin
               failures++;
               $display("[TB] FAIL rr_rdata[%0d]: got %h, expected %h", k,
                        exp_gnt[k-1][0] ? m0_rdata : m1_rdata, 32'hA000_0000 + k);
            end
         end
         next_cycle();
      end
      idle_inputs();
   endtask

   task automatic test_single_read();
      m1_req = 1; m1_we = 0; m1_addr = 32'h0000_0100; s_gnt = 1;
      settle();
      checks++;
      if ({s_req, m1_gnt, m0_gnt} !== 3'b110 || s_addr !== 32'h100) begin
         failures++;
         $display("[TB] FAIL m1_read_req: got s_req=%b gnt1=%b gnt0=%b addr=%h, expected 1 1 0 00000100",
                  s_req, m1_gnt, m0_gnt, s_addr);
      end
      next_cycle();
      m1_req = 0; s_rvalid = 1; s_rdata = 32'hDEAD_BEEF;
      settle();
      checks++;
      if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hDEAD_BEEF || m1_err !== 1'b0 || m0_rvalid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL m1_read_resp: got rv1=%b rd1=%h er1=%b rv0=%b, expected 1 deadbeef 0 0",
                  m1_rvalid, m1_rdata, m1_err, m0_rvalid);
      end
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_out_of_window();
      m0_req = 1; m0_addr = 32'h0010_0000; s_gnt = 0;
      settle();
      checks++;
      if (m0_gnt !== 1'b1 || s_req !== 1'b0 || s_addr !== 32'h0) begin
         failures++;
         $display("[TB] FAIL oow_gnt: got gnt0=%b s_req=%b s_addr=%h, expected 1 0 00000000", m0_gnt, s_req, s_addr);
      end
      next_cycle();
      m0_req = 0; s_rvalid = 1; s_rdata = 32'h5555_5555;
      settle();
      checks++;
      if (m0_rvalid !== 1'b1 || m0_err !== 1'b1 || m0_rdata !== 32'h0 || m1_rvalid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL oow_resp: got rv0=%b er0=%b rd0=%h rv1=%b, expected 1 1 00000000 0",
                  m0_rvalid, m0_err, m0_rdata, m1_rvalid);
      end
      next_cycle();
      idle_inputs();
   endtask

   // Pointer is at m0 here, so the stalled conflict must resolve to m1 then m0.
   task automatic test_stall();
      m0_req = 1; m0_addr = 32'h0000_0030;
      m1_req = 1; m1_addr = 32'h0000_0034;
      for (int k = 0; k < 3; k++) begin
         s_gnt = 0; s_rvalid = (k == 1); s_rdata = 32'h7777_7777;
         settle();
         checks++;
         if ({m0_gnt, m1_gnt} !== 2'b00 || s_req !== 1'b1 || s_addr !== 32'h34) begin
            failures++;
            $display("[TB] FAIL stall[%0d]: got gnt0=%b gnt1=%b s_req=%b s_addr=%h, expected 0 0 1 00000034",
                     k, m0_gnt, m1_gnt, s_req, s_addr);
         end
         if (k == 1) begin
            checks++;
            if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
               failures++;
               $display("[TB] FAIL stall_ignore_rvalid: got rv0=%b rv1=%b, expected 0 0", m0_rvalid, m1_rvalid);
            end
         end
         next_cycle();
      end
      s_gnt = 1; s_rvalid = 0;
      settle();
      checks++;
      if ({m1_gnt, m0_gnt} !== 2'b10) begin
         failures++;
         $display("[TB] FAIL stall_first_gnt: got {gnt1,gnt0}=%b, expected 10", {m1_gnt, m0_gnt});
      end
      next_cycle();
      settle();
      checks++;
      if ({m1_gnt, m0_gnt} !== 2'b01) begin
         failures++;
         $display("[TB] FAIL stall_second_gnt: got {gnt1,gnt0}=%b, expected 01", {m1_gnt, m0_gnt});
      end
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_write();
      m1_req = 1; m1_we = 1; m1_be = 4'b0011; m1_addr = 32'h0000_0040; m1_wdata = 32'h1234_5678; s_gnt = 1;
      settle();
      checks++;
      if (s_req !== 1'b1 || s_we !== 1'b1 || s_be !== 4'b0011 || s_addr !== 32'h40 ||
          s_wdata !== 32'h1234_5678 || m1_gnt !== 1'b1) begin
         failures++;
         $display("[TB] FAIL write_fwd: got req=%b we=%b be=%b addr=%h wdata=%h gnt1=%b, expected 1 1 0011 00000040 12345678 1",
                  s_req, s_we, s_be, s_addr, s_wdata, m1_gnt);
      end
      next_cycle();
      m1_req = 0; m1_we = 0; s_rvalid = 1; s_rdata = 32'hCAFE_F00D;
      settle();
      checks++;
      if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hCAFE_F00D || m1_err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL write_resp: got rv1=%b rd1=%h er1=%b, expected 1 cafef00d 0", m1_rvalid, m1_rdata, m1_err);
      end
      s_rvalid = 0;
      m0_req = 1; m0_we = 1; m0_addr = 32'h8000_0000; m0_wdata = 32'hFFFF_FFFF;
      settle();
      checks++;
      if (s_req !== 1'b0 || s_we !== 1'b0 || s_wdata !== 32'h0 || m0_gnt !== 1'b1) begin
         failures++;
         $display("[TB] FAIL oow_write: got s_req=%b s_we=%b s_wdata=%h gnt0=%b, expected 0 0 00000000 1",
                  s_req, s_we, s_wdata, m0_gnt);
      end
      next_cycle();
      idle_inputs();
      settle();
      checks++;
      if (m0_rvalid !== 1'b1 || m0_err !== 1'b1) begin
         failures++;
         $display("[TB] FAIL oow_write_resp: got rv0=%b er0=%b, expected 1 1", m0_rvalid, m0_err);
      end
      next_cycle();
   endtask

   // Grant m0 (pointer -> m0), reset mid-flight, then a conflict must go to m0 again.
   task automatic test_reset_inflight();
      m0_req = 1; m0_addr = 32'h0000_0080; s_gnt = 1;
      settle();
      checks++;
      if (m0_gnt !== 1'b1) begin
         failures++;
         $display("[TB] FAIL rst_pre_gnt: got gnt0=%b, expected 1", m0_gnt);
      end
      next_cycle();
      m0_req = 0; rst = 1; s_rvalid = 1; s_rdata = 32'hBAD0_BAD0;
      settle();
      checks++;
      if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h0) begin
         failures++;
         $display("[TB] FAIL rst_inflight: got rv0=%b rd0=%h, expected 0 00000000", m0_rvalid, m0_rdata);
      end
      next_cycle();
      rst = 0;
      settle();
      checks++;
      if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || m0_err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL rst_after: got rv0=%b rv1=%b er0=%b, expected 0 0 0", m0_rvalid, m1_rvalid, m0_err);
      end
      s_rvalid = 0;
      m0_req = 1; m0_addr = 32'h0000_0090;
      m1_req = 1; m1_addr = 32'h0000_0094;
      settle();
      checks++;
      if ({m1_gnt, m0_gnt} !== 2'b01) begin
         failures++;
         $display("[TB] FAIL rst_first_conflict: got {gnt1,gnt0}=%b, expected 01", {m1_gnt, m0_gnt});
      end
      next_cycle();
      idle_inputs();
   endtask

   initial begin
      rst = 1;
      idle_inputs();
      #1;
      test_reset();
      test_round_robin();
      test_single_read();
      test_out_of_window();
      test_stall();
      test_write();
      test_reset_inflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
